// File: rtl/dma_ctrl_nch_if.sv
// Bus bundle for dma_ctrl_nch: CPU register port plus the drq/dack, hold and memory/IO strobe side.
// The slave modport is the controller's view; the master modport is the surrounding system's view.
interface dma_ctrl_nch_if #(
   parameter int CHANNELS = 4
);
   localparam int IADDR_W = $clog2(2*CHANNELS+3);

   logic [IADDR_W-1:0]  iaddr;
   logic [7:0]          idata;
   logic                iwe_n;
   logic                ird_n;
   logic [7:0]          odata;
   logic [CHANNELS-1:0] drq;
   logic [CHANNELS-1:0] dack;
   logic                hrq;
   logic                hlda;
   logic [15:0]         oaddr;
   logic                owe_n;
   logic                ord_n;
   logic                oiowe_n;
   logic                oiord_n;
   logic                tc;

   modport slave (
      input  iaddr, idata, iwe_n, ird_n, drq, hlda,
      output odata, dack, hrq, oaddr, owe_n, ord_n, oiowe_n, oiord_n, tc
   );

   modport master (
      output iaddr, idata, iwe_n, ird_n, drq, hlda,
      input  odata, dack, hrq, oaddr, owe_n, ord_n, oiowe_n, oiord_n, tc
   );
endinterface

// File: rtl/dma_ctrl_nch.sv
// N-channel DMA controller: byte-flip-flop register file, shadow autoload, fixed/rotating priority, TC-stop.
// One FSM state per ce, all outputs registered; DMA_EXT_WRITE_EN stretches write strobes over S1..S2.
module dma_ctrl_nch #(
   parameter int CHANNELS = 4
) (
   input logic           clk,
   input logic           reset_n,
   input logic           ce,
   dma_ctrl_nch_if.slave bus
);
   localparam int IADDR_W = $clog2(2*CHANNELS+3);
   localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int A_MODE0 = 2*CHANNELS;
   localparam int A_MODE1 = 2*CHANNELS + 1;
   localparam int A_AUTO  = 2*CHANNELS + 2;

   typedef enum logic [2:0] {IDLE, S0, S1, S2, S3} state_t;

   state_t              state;
   logic [15:0]         addr_live [CHANNELS];
   logic [15:0]         cnt_live  [CHANNELS];
   logic [15:0]         addr_sh   [CHANNELS];
   logic [15:0]         cnt_sh    [CHANNELS];
   logic [CHANNELS-1:0] enable;
   logic [CHANNELS-1:0] autoload;
   logic [CHANNELS-1:0] tc_flag;
   logic [2:0]          mode1;
   logic                ff;
   logic [CW-1:0]       prio;
   logic [CW-1:0]       ch;

   logic [CHANNELS-1:0] req;
   logic [CHANNELS-1:0] en_after;
   logic [CW-1:0]       base;
   logic [CW-1:0]       idx;
   logic [CW-1:0]       win_ch;
   logic                win_vld;
   logic [CW-1:0]       reg_ch;
   logic                is_chan;
   logic                tc_hit;
   logic                stop_clr;
   logic [7:0]          rd_dat;

   function automatic logic [CHANNELS-1:0] onehot(input logic [CW-1:0] k);
      logic [CHANNELS-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   assign req      = bus.drq & enable;
   assign base     = mode1[0] ? prio : '0;
   assign reg_ch   = CW'(bus.iaddr >> 1);
   assign is_chan  = (int'(bus.iaddr) < A_MODE0);
   assign tc_hit   = (cnt_live[ch][13:0] == 14'd0);
   assign stop_clr = tc_hit & ~autoload[ch] & mode1[1];
   // Channel that TC-stops in S3 must not win the re-arbitration decision on the same edge.
   assign en_after = enable & ~(stop_clr ? onehot(ch) : '0);

   // Scan from lowest to highest priority so the highest-priority requester is written last.
   always_comb begin
      win_ch  = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int i = CHANNELS-1; i >= 0; i--) begin
         idx = CW'((int'(base) + i) % CHANNELS);
         if (req[idx]) begin
            win_ch  = idx;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      rd_dat = '0;
      if (is_chan) begin
         if (bus.iaddr[0])
            rd_dat = ff ? cnt_live[reg_ch][15:8] : cnt_live[reg_ch][7:0];
         else
            rd_dat = ff ? addr_live[reg_ch][15:8] : addr_live[reg_ch][7:0];
      end else if (int'(bus.iaddr) == A_MODE0) begin
         rd_dat = 8'(tc_flag);
      end else if (int'(bus.iaddr) == A_MODE1) begin
         rd_dat = 8'(mode1);
      end else if (int'(bus.iaddr) == A_AUTO) begin
         rd_dat = 8'(autoload);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         for (int i = 0; i < CHANNELS; i++) begin
            addr_live[i] <= '0;
            cnt_live[i]  <= '0;
            addr_sh[i]   <= '0;
            cnt_sh[i]    <= '0;
         end
         enable      <= '0;
         autoload    <= '0;
         tc_flag     <= '0;
         mode1       <= '0;
         ff          <= 1'b0;
         prio        <= '0;
         ch          <= '0;
         bus.hrq     <= 1'b0;
         bus.dack    <= '0;
         bus.oaddr   <= '0;
         bus.owe_n   <= 1'b1;
         bus.ord_n   <= 1'b1;
         bus.oiowe_n <= 1'b1;
         bus.oiord_n <= 1'b1;
         bus.tc      <= 1'b0;
         bus.odata   <= '0;
      end else if (ce) begin
         bus.tc <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  bus.hrq <= 1'b1;
                  state   <= S0;
               end
            end
            S0: begin
               if (!(|req)) begin
                  bus.hrq <= 1'b0;
                  state   <= IDLE;
               end else if (bus.hlda) begin
                  state <= S1;
               end
            end
            S1: begin
               if (win_vld) begin
                  ch        <= win_ch;
                  bus.oaddr <= addr_live[win_ch];
                  bus.dack  <= onehot(win_ch);
                  state     <= S2;
`ifdef DMA_EXT_WRITE_EN
                  if (mode1[2]) begin
                     if (cnt_live[win_ch][15:14] == 2'b01) bus.owe_n   <= 1'b0;
                     if (cnt_live[win_ch][15:14] == 2'b10) bus.oiowe_n <= 1'b0;
                  end
`endif
               end else begin
                  bus.hrq  <= 1'b0;
                  bus.dack <= '0;
                  state    <= IDLE;
               end
            end
            S2: begin
               case (cnt_live[ch][15:14])
                  2'b01: begin
                     bus.oiord_n <= 1'b0;
                     bus.owe_n   <= 1'b0;
                  end
                  2'b10: begin
                     bus.ord_n   <= 1'b0;
                     bus.oiowe_n <= 1'b0;
                  end
                  default: ;
               endcase
               state <= S3;
            end
            S3: begin
               bus.owe_n   <= 1'b1;
               bus.ord_n   <= 1'b1;
               bus.oiowe_n <= 1'b1;
               bus.oiord_n <= 1'b1;
               if (mode1[0])
                  prio <= (int'(ch) == CHANNELS-1) ? '0 : ch + 1'b1;
               if (tc_hit) begin
                  bus.tc      <= 1'b1;
                  tc_flag[ch] <= 1'b1;
               end
               if (tc_hit && autoload[ch]) begin
                  addr_live[ch] <= addr_sh[ch];
                  cnt_live[ch]  <= cnt_sh[ch];
               end else begin
                  addr_live[ch]       <= addr_live[ch] + 16'd1;
                  cnt_live[ch][13:0]  <= cnt_live[ch][13:0] - 14'd1;
                  if (stop_clr) enable[ch] <= 1'b0;
               end
               if (bus.hlda && |(bus.drq & en_after)) begin
                  state <= S1;
               end else begin
                  bus.hrq  <= 1'b0;
                  bus.dack <= '0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // CPU access sits after the FSM so a register write overrides an S3 update on the same edge.
         if (!bus.iwe_n) begin
            if (is_chan) begin
               if (bus.iaddr[0]) begin
                  if (ff) begin
                     cnt_live[reg_ch][15:8] <= bus.idata;
                     cnt_sh[reg_ch][15:8]   <= bus.idata;
                  end else begin
                     cnt_live[reg_ch][7:0]  <= bus.idata;
                     cnt_sh[reg_ch][7:0]    <= bus.idata;
                  end
               end else begin
                  if (ff) begin
                     addr_live[reg_ch][15:8] <= bus.idata;
                     addr_sh[reg_ch][15:8]   <= bus.idata;
                  end else begin
                     addr_live[reg_ch][7:0]  <= bus.idata;
                     addr_sh[reg_ch][7:0]    <= bus.idata;
                  end
               end
               ff <= ~ff;
            end else if (int'(bus.iaddr) == A_MODE0) begin
               enable <= bus.idata[CHANNELS-1:0];
               ff     <= 1'b0;
            end else if (int'(bus.iaddr) == A_MODE1) begin
`ifdef DMA_EXT_WRITE_EN
               mode1 <= bus.idata[2:0];
`else
               mode1 <= {1'b0, bus.idata[1:0]};
`endif
               ff    <= 1'b0;
            end else if (int'(bus.iaddr) == A_AUTO) begin
               autoload <= bus.idata[CHANNELS-1:0];
               ff       <= 1'b0;
            end
         end else if (!bus.ird_n) begin
            bus.odata <= rd_dat;
            if (is_chan)
               ff <= ~ff;
            else if (int'(bus.iaddr) == A_MODE0)
               tc_flag <= '0;
         end
      end
   end
endmodule

// File: tb/tb_dma_ctrl_nch.sv
// Directed bench for dma_ctrl_nch (CHANNELS=4): single transfer, TC-stop, autoload, priority, ce stall, wrap/reset, ext write.
module tb_dma_ctrl_nch;
   logic clk;
   logic reset_n;
   logic ce;
   int   errors;
   int   checks;
   logic [7:0] d;
   logic [3:0] strb;

   dma_ctrl_nch_if #(.CHANNELS(4)) bus ();

   dma_ctrl_nch #(.CHANNELS(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (ce),
      .bus     (bus)
   );

   assign strb = {bus.owe_n, bus.ord_n, bus.oiowe_n, bus.oiord_n};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] v);
      @(negedge clk);
      bus.iaddr = a;
      bus.idata = v;
      bus.iwe_n = 1'b0;
      @(negedge clk);
      bus.iwe_n = 1'b1;
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] v);
      @(negedge clk);
      bus.iaddr = a;
      bus.ird_n = 1'b0;
      @(negedge clk);
      v = bus.odata;
      bus.ird_n = 1'b1;
   endtask

   task automatic prog_ch(input int k, input logic [15:0] a, input logic [15:0] c);
      logic [3:0] ra;
      logic [3:0] rc;
      ra = 4'(2*k);
      rc = 4'(2*k+1);
      wr(ra, a[7:0]);
      wr(ra, a[15:8]);
      wr(rc, c[7:0]);
      wr(rc, c[15:8]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.drq  = '0;
      bus.hlda = 1'b0;
      reset_n  = 1'b0;
      @(negedge clk);
      reset_n  = 1'b1;
   endtask

   task automatic wait_hrq(input string tag);
      int n;
      n = 0;
      while (bus.hrq !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(tag, bus.hrq, 1);
   endtask

   initial begin
      clk       = 1'b0;
      reset_n   = 1'b0;
      ce        = 1'b1;
      errors    = 0;
      checks    = 0;
      bus.iaddr = '0;
      bus.idata = '0;
      bus.iwe_n = 1'b1;
      bus.ird_n = 1'b1;
      bus.drq   = '0;
      bus.hlda  = 1'b0;
      tick();
      tick();
      chk("rst_hrq", bus.hrq, 0);
      chk("rst_dack", bus.dack, 0);
      chk("rst_oaddr", bus.oaddr, 0);
      chk("rst_strb", strb, 4'hF);
      chk("rst_tc", bus.tc, 0);
      chk("rst_odata", bus.odata, 0);
      reset_n = 1'b1;

      // Single read-type transfer pair on ch2
      prog_ch(2, 16'h1234, 16'h8001);
      bus.drq = 4'b0100;
      wr(4'd8, 8'h04);
      wait_hrq("t1_hrq");
      bus.hlda = 1'b1;
      tick();
      tick();
      chk("t1_oaddr0", bus.oaddr, 16'h1234);
      chk("t1_dack0", bus.dack, 4'b0100);
      chk("t1_s1_strb", strb, 4'hF);
      tick();
      chk("t1_s2_strb", strb, 4'b1001);
      tick();
      chk("t1_s3_strb", strb, 4'hF);
      chk("t1_tc0", bus.tc, 0);
      chk("t1_hrq_keep", bus.hrq, 1);
      tick();
      chk("t1_oaddr1", bus.oaddr, 16'h1235);
      tick();
      chk("t1_s2b_strb", strb, 4'b1001);
      tick();
      chk("t1_tc1", bus.tc, 1);
      bus.drq  = '0;
      bus.hlda = 1'b0;
      tick();
      chk("t1_hrq_drop", bus.hrq, 0);
      chk("t1_dack_drop", bus.dack, 0);
      chk("t1_tc_pulse", bus.tc, 0);
      rd(4'd8, d);
      chk("t1_status", d, 8'h04);
      rd(4'd8, d);
      chk("t1_status_clr", d, 8'h00);
      rd(4'd4, d);
      chk("t1_addr_lo", d, 8'h36);
      rd(4'd4, d);
      chk("t1_addr_hi", d, 8'h12);
      rd(4'd5, d);
      chk("t1_cnt_lo", d, 8'hFF);
      rd(4'd5, d);
      chk("t1_cnt_hi", d, 8'hBF);

      // TC-stop
      do_reset();
      prog_ch(2, 16'h1234, 16'h8001);
      wr(4'd9, 8'h02);
      bus.drq = 4'b0100;
      wr(4'd8, 8'h04);
      wait_hrq("t2_hrq");
      bus.hlda = 1'b1;
      repeat (7) tick();
      chk("t2_tc", bus.tc, 1);
      chk("t2_hrq_drop", bus.hrq, 0);
      chk("t2_dack_drop", bus.dack, 0);
      repeat (4) tick();
      chk("t2_hrq_stays0", bus.hrq, 0);

      // Autoload
      do_reset();
      prog_ch(2, 16'hE000, 16'h8000);
      wr(4'd10, 8'h04);
      bus.drq = 4'b0100;
      wr(4'd8, 8'h04);
      wait_hrq("t3_hrq");
      bus.hlda = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_oaddr", bus.oaddr, 16'hE000);
         tick();
         tick();
         chk("t3_tc", bus.tc, 1);
         chk("t3_hrq_keep", bus.hrq, 1);
      end
      bus.drq  = '0;
      bus.hlda = 1'b0;
      tick();
      rd(4'd8, d);
      chk("t3_status", d, 8'h04);

      // Rotating priority, verify-type transfers
      do_reset();
      prog_ch(0, 16'h0100, 16'h0003);
      prog_ch(2, 16'h0200, 16'h0003);
      wr(4'd9, 8'h01);
      bus.drq = 4'b0101;
      wr(4'd8, 8'h05);
      wait_hrq("t4_hrq");
      bus.hlda = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_dack", bus.dack, (i % 2 == 0) ? 4'b0001 : 4'b0100);
         chk("t4_oaddr", bus.oaddr, ((i % 2 == 0) ? 16'h0100 : 16'h0200) + 16'(i / 2));
         tick();
         chk("t4_verify_strb", strb, 4'hF);
         tick();
      end

      // Fixed priority, then a ce stall
      do_reset();
      prog_ch(0, 16'h0100, 16'h0003);
      prog_ch(2, 16'h0200, 16'h0003);
      bus.drq = 4'b0101;
      wr(4'd8, 8'h05);
      wait_hrq("t5_hrq");
      bus.hlda = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_dack", bus.dack, 4'b0001);
         chk("t5_oaddr", bus.oaddr, 16'h0100 + 16'(i));
         tick();
         tick();
      end
      ce = 1'b0;
      repeat (3) tick();
      chk("t5_ce_oaddr", bus.oaddr, 16'h0102);
      chk("t5_ce_hrq", bus.hrq, 1);
      ce = 1'b1;
      tick();
      chk("t5_ce_resume", bus.oaddr, 16'h0103);

      // Address wrap, write type, async reset in S2
      do_reset();
      prog_ch(1, 16'hFFFF, 16'h4001);
      bus.drq = 4'b0010;
      wr(4'd8, 8'h02);
      wait_hrq("t6_hrq");
      bus.hlda = 1'b1;
      tick();
      tick();
      chk("t6_oaddr0", bus.oaddr, 16'hFFFF);
      tick();
      chk("t6_wr_strb", strb, 4'b0110);
      tick();
      tick();
      chk("t6_oaddr_wrap", bus.oaddr, 16'h0000);
      chk("t6_dack", bus.dack, 4'b0010);
      tick();
      chk("t6_wr_strb2", strb, 4'b0110);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_strb", strb, 4'hF);
      chk("t6_rst_hrq", bus.hrq, 0);
      chk("t6_rst_dack", bus.dack, 0);
      @(negedge clk);
      reset_n = 1'b1;
      rd(4'd2, d);
      chk("t6_addr_lo0", d, 8'h00);
      rd(4'd2, d);
      chk("t6_addr_hi0", d, 8'h00);
      repeat (3) tick();
      chk("t6_idle_hrq", bus.hrq, 0);

      // Extended write on a write-type transfer
      do_reset();
      prog_ch(0, 16'h4000, 16'h4000);
      wr(4'd9, 8'h04);
      bus.drq = 4'b0001;
      wr(4'd8, 8'h01);
      wait_hrq("t7_hrq");
      bus.hlda = 1'b1;
      tick();
      tick();
`ifdef DMA_EXT_WRITE_EN
      chk("t7_s1_strb", strb, 4'b0111);
`else
      chk("t7_s1_strb", strb, 4'hF);
`endif
      tick();
      chk("t7_s2_strb", strb, 4'b0110);
      tick();
      chk("t7_s3_strb", strb, 4'hF);
      chk("t7_tc", bus.tc, 1);
      bus.drq  = '0;
      bus.hlda = 1'b0;
      tick();
      rd(4'd9, d);
`ifdef DMA_EXT_WRITE_EN
      chk("t7_mode1", d, 8'h04);
`else
      chk("t7_mode1", d, 8'h00);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
